core2wb_pipe: RTL and testbench
===============================

Name: core2wb_pipe

Overview:
- Parametrised successor to the single-outstanding core-to-Wishbone bridge. Converts the Ibex-style req/gnt/rvalid memory port into a Wishbone B4 pipelined master.
- Allows up to MaxOutstanding in-flight transfers.
- Adds a response-timeout watchdog that aborts a hung cycle and returns error responses to the core.
- One instance is used per Ibex port (instruction and data); the instruction instance ties we/be/wdata to constants.

Parameters:
AddrWidth, 32, address width of core and Wishbone address
DataWidth, 32, data width; multiple of 8
MaxOutstanding, 4, maximum issued-but-unanswered transfers; >= 1
TimeoutCycles, 256, cycles without any ack/err while outstanding > 0 before abort; 0 disables the watchdog

Ports:
clk  in  1  clock (the Wishbone clock)
rst  in  1  synchronous reset, active-high
core_req  in  1  request valid; held until granted
core_gnt  out  1  request accepted this cycle
core_rvalid  out  1  response valid; exactly one per granted request
core_we  in  1  write enable
core_be  in  DataWidth/8  byte enables
core_addr  in  AddrWidth  address
core_wdata  in  DataWidth  write data
core_rdata  out  DataWidth  read data, valid with core_rvalid
core_err  out  1  error response, valid with core_rvalid
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_sel  out  DataWidth/8  byte select
wb_adr  out  AddrWidth  address
wb_dat_o  out  DataWidth  write data
wb_stall  in  1  slave stall
wb_ack  in  1  slave acknowledge
wb_err  in  1  slave error
wb_dat_i  in  DataWidth  read data

Behaviour:
- States: IDLE, BUSY, ABORT. Counter cnt in 0..MaxOutstanding. Timer tmr in 0..TimeoutCycles.
- Reset, which overrides everything including mid-transfer:
  - state=IDLE, cnt=0, tmr=0.
  - All outputs 0: wb_cyc, wb_stb, core_gnt, core_rvalid, core_err; core_rdata=0.
- Request path (combinational):
  - wb_stb = core_req & (state!=ABORT) & (cnt<MaxOutstanding).
  - wb_adr/wb_we/wb_sel/wb_dat_o = core_addr/core_we/core_be/core_wdata.
  - issue = wb_stb & ~wb_stall; core_gnt = issue.
- wb_cyc = wb_stb | (state==BUSY).
- Response path (combinational, zero latency):
  - resp = (wb_ack|wb_err) & (cnt>0) & (state==BUSY).
  - core_rvalid = resp; core_rdata = wb_dat_i; core_err = wb_err.
  - wb_ack and wb_err together: treated as an error.
  - ack/err arriving with cnt==0: ignored, no rvalid.
- Counter: cnt_next = cnt + issue - resp. Simultaneous issue and resp leave cnt unchanged. cnt never exceeds MaxOutstanding; wb_stb is blocked at full.
- Transitions:
  - IDLE -> BUSY on issue.
  - BUSY -> IDLE when cnt_next==0.
  - BUSY -> ABORT when TimeoutCycles>0 & tmr==TimeoutCycles-1 & ~resp & cnt>0.
  - ABORT -> IDLE when cnt reaches 0.
- Timer: cleared on resp, on issue, or when cnt==0; otherwise increments in BUSY.
- ABORT state:
  - wb_cyc=0 and wb_stb=0; wb_ack/wb_err ignored.
  - Emits core_rvalid=1, core_err=1, core_rdata=0 once per cycle, decrementing cnt each cycle until 0.
  - core_gnt=0 throughout.
- The Ibex ordering rule holds: responses are returned in issue order. Wishbone slaves respond in order.

Decomposition:
- Package core2wb_pkg: state enum (IDLE, BUSY, ABORT) and a function clog2-based counter width helper.
- One sub-module, wb_timeout_cnt: a parametrised watchdog with inputs clear/enable and output expire.

Test Plan:
1. Back-to-back reads, slave with no stall and 1-cycle ack: 4 reads to 0x100..0x10C.
   - 4 consecutive gnt cycles.
   - 4 rvalid with rdata 0xA0..0xA3 in order.
   - cnt peaks at 1; wb_cyc drops the cycle after the last ack.
2. Slave delays ack by 10 cycles, MaxOutstanding=4, core issues 6 reads.
   - Exactly 4 gnts, then core_gnt=0 and wb_stb=0 until the first ack.
   - All 6 rvalid in order.
3. Simultaneous issue and ack at cnt=MaxOutstanding-1: cnt unchanged.
   - wb_stb stays high the next cycle.
4. Write with be=4'b0100, wdata 0x00AB0000, slave returns wb_err.
   - wb_sel=0100.
   - core_rvalid=1 with core_err=1.
   - Returns to IDLE.
5. TimeoutCycles=8, 3 outstanding, slave silent.
   - At cycle 8 after the last issue: wb_cyc=0.
   - 3 consecutive rvalid with err=1, then IDLE.
   - A late wb_ack arriving in ABORT produces no rvalid.
6. rst asserted with 2 outstanding.
   - Next cycle wb_cyc=0 and cnt=0.
   - A following ack produces no rvalid.
   - A fresh read completes normally.

Source files
------------

// File: rtl/core2wb_pkg.sv
// Shared types and helpers for the core-to-Wishbone pipelined bridge.
package core2wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort
  } state_e;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Response watchdog: counts enabled cycles and flags expiry on the last allowed cycle.
module wb_timeout_cnt
  import core2wb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TmrW = cnt_width(TimeoutCycles);
  localparam logic [TmrW-1:0] LastTick = TmrW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  logic [TmrW-1:0] tmr_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tmr_q <= '0;
    end else if (enable && (TimeoutCycles != 0)) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  // A zero timeout disables the watchdog entirely.
  assign expire = enable && (TimeoutCycles != 0) && (tmr_q == LastTick);

endmodule

// File: rtl/core2wb_pipe.sv
// Ibex req/gnt/rvalid port to Wishbone B4 pipelined master with several outstanding
// transfers and a watchdog that aborts a hung cycle with error responses.
module core2wb_pipe
  import core2wb_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_req,
  output logic                   core_gnt,
  output logic                   core_rvalid,
  input  logic                   core_we,
  input  logic [DataWidth/8-1:0] core_be,
  input  logic [AddrWidth-1:0]   core_addr,
  input  logic [DataWidth-1:0]   core_wdata,
  output logic [DataWidth-1:0]   core_rdata,
  output logic                   core_err,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [DataWidth/8-1:0] wb_sel,
  output logic [AddrWidth-1:0]   wb_adr,
  output logic [DataWidth-1:0]   wb_dat_o,
  input  logic                   wb_stall,
  input  logic                   wb_ack,
  input  logic                   wb_err,
  input  logic [DataWidth-1:0]   wb_dat_i
);

  localparam int unsigned CntW = cnt_width(MaxOutstanding);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy, abort, stb, issue, resp, expire, tmr_clear, tmr_enable;

  always_comb begin
    busy  = (state_q == StBusy);
    abort = (state_q == StAbort);
    stb   = ~rst & core_req & ~abort & (cnt_q < CntMax);
    issue = stb & ~wb_stall;
    // While aborting, every cycle retires one outstanding transfer as an error.
    resp  = ~rst & (cnt_q != '0) & ((busy & (wb_ack | wb_err)) | abort);
  end

  assign wb_stb      = stb;
  assign wb_cyc      = stb | (~rst & busy);
  assign wb_we       = core_we;
  assign wb_sel      = core_be;
  assign wb_adr      = core_addr;
  assign wb_dat_o    = core_wdata;
  assign core_gnt    = issue;
  assign core_rvalid = resp;
  assign core_rdata  = (rst | abort) ? '0 : wb_dat_i;
  assign core_err    = resp & (abort | wb_err);

  assign tmr_clear  = resp | issue | (cnt_q == '0);
  assign tmr_enable = busy & ~resp & (cnt_q != '0);

  wb_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .enable(tmr_enable),
    .expire(expire)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !resp) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!issue && resp) begin
      cnt_d = cnt_q - 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StBusy;
      StBusy: begin
        if (expire) begin
          state_d = StAbort;
        end else if (cnt_d == '0) begin
          state_d = StIdle;
        end
      end
      StAbort: if (cnt_d == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_core2wb_pipe.sv
// Directed bench for core2wb_pipe: in-order Wishbone slave model plus response scoreboard.
module tb_core2wb_pipe;
  import core2wb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;
  localparam int unsigned TO = 8;

  logic          clk, rst;
  logic          core_req, core_gnt, core_rvalid, core_we, core_err;
  logic [3:0]    core_be, wb_sel;
  logic [AW-1:0] core_addr, wb_adr;
  logic [DW-1:0] core_wdata, core_rdata, wb_dat_o, wb_dat_i;
  logic          wb_cyc, wb_stb, wb_we, wb_stall, wb_ack, wb_err;

  core2wb_pipe #(
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .MaxOutstanding(MO),
    .TimeoutCycles (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_req   (core_req),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_we    (core_we),
    .core_be    (core_be),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_err   (core_err),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_adr     (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_stall   (wb_stall),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_dat_i   (wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Pending core requests and the responses they should produce.
  logic [31:0] rq_addr[$];
  logic        rq_we[$];
  logic [3:0]  rq_be[$];
  logic [31:0] rq_wdat[$];
  logic [31:0] ex_dat[$];
  logic        ex_err[$];

  // Slave model: answers in order sl_lat cycles after each accepted request.
  int          cyc_n = 0;
  int          sl_due[$];
  logic [31:0] sl_dat[$];
  int          sl_lat = 1;
  bit          sl_err = 0;
  bit          sl_silent = 0;
  int          inj_ack = -1;
  logic        rst_v = 1'b1;

  bit   tr_gnt[$], tr_stb[$], tr_cyc[$], tr_rv[$], tr_ack[$];
  int   tr_cnt[$];
  int   n_gnt, n_rv, n_ack, max_cnt;
  logic [3:0]  last_sel;
  logic        last_we;
  logic [31:0] last_wdat;

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input bit expect_resp,
                          input logic [31:0] xd, input logic xe);
    rq_addr.push_back(a);
    rq_we.push_back(we);
    rq_be.push_back(be);
    rq_wdat.push_back(wd);
    if (expect_resp) begin
      ex_dat.push_back(xd);
      ex_err.push_back(xe);
    end
  endtask

  task automatic run(input int n);
    tr_gnt.delete(); tr_stb.delete(); tr_cyc.delete(); tr_rv.delete(); tr_ack.delete();
    tr_cnt.delete();
    n_gnt = 0; n_rv = 0; n_ack = 0; max_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst        = rst_v;
      core_req   = (rq_addr.size() > 0);
      core_addr  = core_req ? rq_addr[0] : '0;
      core_we    = core_req ? rq_we[0] : 1'b0;
      core_be    = core_req ? rq_be[0] : '0;
      core_wdata = core_req ? rq_wdat[0] : '0;
      wb_ack     = 1'b0;
      wb_err     = 1'b0;
      wb_dat_i   = 32'hDEAD_BEEF;
      if (!sl_silent && sl_due.size() > 0 && sl_due[0] <= cyc_n) begin
        if (sl_err) wb_err = 1'b1;
        else        wb_ack = 1'b1;
        wb_dat_i = sl_dat[0];
        sl_due.delete(0);
        sl_dat.delete(0);
      end
      if (cyc_n == inj_ack) begin
        wb_ack   = 1'b1;
        wb_dat_i = 32'h0000_00EE;
      end
      #1;
      tr_gnt.push_back(core_gnt);
      tr_stb.push_back(wb_stb);
      tr_cyc.push_back(wb_cyc);
      tr_rv.push_back(core_rvalid);
      tr_ack.push_back(wb_ack | wb_err);
      tr_cnt.push_back(int'(dut.cnt_q));
      if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
      if (wb_ack | wb_err) n_ack++;
      if (core_gnt) begin
        n_gnt++;
        last_sel  = wb_sel;
        last_we   = wb_we;
        last_wdat = wb_dat_o;
        sl_due.push_back(cyc_n + sl_lat);
        sl_dat.push_back(32'hA0 + 32'(wb_adr[7:2]));
        rq_addr.delete(0); rq_we.delete(0); rq_be.delete(0); rq_wdat.delete(0);
      end
      if (core_rvalid) begin
        n_rv++;
        if (ex_dat.size() == 0) begin
          check_val("rv_extra", 32'd1, 32'd0);
        end else begin
          check_val("rdata", core_rdata, ex_dat[0]);
          check_val("rerr", 32'(core_err), 32'(ex_err[0]));
          ex_dat.delete(0);
          ex_err.delete(0);
        end
      end
      cyc_n++;
    end
  endtask

  int  first_ack, last_ack;
  bit  viol;

  initial begin
    rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_be = '0; core_addr = '0;
    core_wdata = '0; wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;

    // Reset: a pending request and a stray ack must both be ignored.
    push_req(32'h100, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0);
    inj_ack = 1;
    run(3);
    check_val("rst_gnt", 32'(n_gnt), 32'd0);
    check_val("rst_stb", 32'(tr_stb[1]), 32'd0);
    check_val("rst_cyc", 32'(tr_cyc[1]), 32'd0);
    check_val("rst_rv", 32'(n_rv), 32'd0);
    check_val("rst_cnt", 32'(tr_cnt[2]), 32'd0);
    rq_addr.delete(); rq_we.delete(); rq_be.delete(); rq_wdat.delete();
    inj_ack = -1;
    rst_v = 1'b0;

    // 1: back-to-back reads, 1-cycle ack.
    sl_lat = 1;
    for (int i = 0; i < 4; i++)
      push_req(32'h100 + 32'(4 * i), 1'b0, 4'hF, '0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    run(10);
    check_val("t1_gnt_n", 32'(n_gnt), 32'd4);
    check_val("t1_gnt_b2b", 32'(tr_gnt[0] & tr_gnt[1] & tr_gnt[2] & tr_gnt[3]), 32'd1);
    check_val("t1_rv_n", 32'(n_rv), 32'd4);
    check_val("t1_cnt_max", 32'(max_cnt), 32'd1);
    last_ack = -1;
    for (int i = 0; i < tr_ack.size(); i++) if (tr_ack[i]) last_ack = i;
    check_val("t1_last_ack", 32'(last_ack), 32'd4);
    check_val("t1_cyc_ack", 32'(tr_cyc[4]), 32'd1);
    check_val("t1_cyc_drop", 32'(tr_cyc[5]), 32'd0);

    // 2: 10-cycle ack latency, 6 reads against 4 slots.
    sl_lat = 10;
    for (int i = 0; i < 6; i++)
      push_req(32'h200 + 32'(4 * i), 1'b0, 4'hF, '0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    run(30);
    first_ack = -1;
    for (int i = tr_ack.size() - 1; i >= 0; i--) if (tr_ack[i]) first_ack = i;
    check_val("t2_first_ack", 32'(first_ack), 32'd10);
    viol = 0;
    for (int i = 4; i <= 10; i++) if (tr_gnt[i] || tr_stb[i]) viol = 1;
    check_val("t2_full_block", 32'(viol), 32'd0);
    check_val("t2_gnt_early", 32'(tr_gnt[0] & tr_gnt[1] & tr_gnt[2] & tr_gnt[3]), 32'd1);
    check_val("t2_cnt_max", 32'(max_cnt), 32'd4);
    check_val("t2_gnt_n", 32'(n_gnt), 32'd6);
    check_val("t2_rv_n", 32'(n_rv), 32'd6);
    check_val("t2_cnt_end", 32'(tr_cnt[29]), 32'd0);

    // 3: issue and ack together at cnt = MaxOutstanding-1.
    sl_lat = 3;
    for (int i = 0; i < 5; i++)
      push_req(32'h100 + 32'(4 * i), 1'b0, 4'hF, '0, 1'b1, 32'hA0 + 32'(i), 1'b0);
    run(12);
    check_val("t3_cnt3", 32'(tr_cnt[3]), 32'd3);
    check_val("t3_both", 32'(tr_gnt[3] & tr_ack[3]), 32'd1);
    check_val("t3_cnt_hold", 32'(tr_cnt[4]), 32'd3);
    check_val("t3_stb_next", 32'(tr_stb[4]), 32'd1);
    check_val("t3_rv_n", 32'(n_rv), 32'd5);

    // 4: byte write answered with wb_err.
    sl_lat = 2;
    sl_err = 1;
    push_req(32'h300, 1'b1, 4'b0100, 32'h00AB_0000, 1'b1, 32'hA0, 1'b1);
    run(6);
    sl_err = 0;
    check_val("t4_sel", 32'(last_sel), 32'h4);
    check_val("t4_we", 32'(last_we), 32'd1);
    check_val("t4_wdat", last_wdat, 32'h00AB_0000);
    check_val("t4_rv_n", 32'(n_rv), 32'd1);
    check_val("t4_cyc_end", 32'(tr_cyc[3]), 32'd0);
    check_val("t4_idle", 32'(dut.state_q), 32'(StIdle));

    // 5: silent slave, watchdog abort after 8 idle BUSY cycles; late ack in ABORT.
    sl_silent = 1;
    inj_ack = cyc_n + 12;
    for (int i = 0; i < 3; i++)
      push_req(32'h400 + 32'(4 * i), 1'b0, 4'hF, '0, 1'b1, 32'h0, 1'b1);
    run(20);
    check_val("t5_gnt_n", 32'(n_gnt), 32'd3);
    check_val("t5_cyc_busy", 32'(tr_cyc[10]), 32'd1);
    check_val("t5_cyc_abort", 32'(tr_cyc[11]), 32'd0);
    check_val("t5_rv_pre", 32'(tr_rv[10]), 32'd0);
    check_val("t5_rv_burst", 32'(tr_rv[11] & tr_rv[12] & tr_rv[13]), 32'd1);
    check_val("t5_rv_post", 32'(tr_rv[14]), 32'd0);
    check_val("t5_rv_n", 32'(n_rv), 32'd3);
    check_val("t5_late_ack", 32'(n_ack), 32'd1);
    check_val("t5_idle", 32'(dut.state_q), 32'(StIdle));
    sl_silent = 0;
    inj_ack = -1;
    sl_due.delete();
    sl_dat.delete();

    // 6: reset with two transfers outstanding.
    sl_lat = 20;
    push_req(32'h500, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0);
    push_req(32'h504, 1'b0, 4'hF, '0, 1'b0, '0, 1'b0);
    run(4);
    check_val("t6_cnt_pre", 32'(tr_cnt[3]), 32'd2);
    rst_v = 1'b1;
    run(1);
    check_val("t6_cyc_rst", 32'(tr_cyc[0]), 32'd0);
    rst_v = 1'b0;
    run(25);
    check_val("t6_cyc_after", 32'(tr_cyc[0]), 32'd0);
    check_val("t6_cnt_after", 32'(tr_cnt[0]), 32'd0);
    check_val("t6_stale_acks", 32'(n_ack), 32'd2);
    check_val("t6_rv_stale", 32'(n_rv), 32'd0);
    sl_lat = 1;
    push_req(32'h104, 1'b0, 4'hF, '0, 1'b1, 32'hA1, 1'b0);
    run(5);
    check_val("t6_fresh_rv", 32'(n_rv), 32'd1);
    check_val("t6_fresh_cyc", 32'(tr_cyc[3]), 32'd0);
    check_val("t6_sb_empty", 32'(ex_dat.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
